arm_instr_encoder: RTL and testbench
====================================

// Module: arm_instr_encoder
// PURPOSE
// - Inverse of the instruction decoder: packs field bundles (DP/MUL class, opcode, regs, operand2) into 32-bit ARM words.
// - Buffers encoded words in a small FIFO and emits them with a program-memory address, for loading instruction memory and self-checking the decoder.
// - Sits between the testbench/loader front end and the instruction memory write port.
// PARAMETERS
// - ADDR_W  8     width of the emitted word address; wraps at 2**ADDR_W
// - DEPTH   4     output FIFO depth in words (power of two, >=2)
// - COND    4'hE  condition field placed in bits[31:28] (AL)
// PORTS
// - clk            in   1       single clock, rising edge
// - rst_n          in   1       asynchronous, active-low reset
// - in_valid       in   1       field bundle valid
// - in_ready       out  1       encoder can accept; = !fifo_full
// - in_kind        in   2       0 DP, 1 MUL, 2/3 reserved (illegal)
// - in_opcode      in   4       DP opcode (AND..MVN, ARM encoding)
// - in_mul         in   3       MUL sub-op (000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL)
// - in_s           in   1       set-flags request
// - in_imm_mode    in   1       DP: 1 rotated immediate, 0 register operand
// - in_rn,in_rd    in   4 each  Rn / Rd (MUL long: in_rd = RdHi, in_rn = RdLo)
// - in_rm,in_rs    in   4 each  Rm / Rs
// - in_imm8        in   8       immediate value
// - in_rot         in   4       immediate rotate field
// - in_shift_type  in   2       LSL/LSR/ASR/ROR
// - in_shift_amt   in   5       immediate shift amount
// - in_reg_shift   in   1       1: shift by Rs
// - out_valid      out  1       FIFO head valid
// - out_ready      in   1       consumer takes word
// - out_instr      out  32      encoded word at FIFO head
// - out_addr       out  ADDR_W  address of out_instr
// - err_valid      out  1       one-cycle pulse: last accepted bundle illegal
// - err_code       out  2       0 none, 1 reserved kind, 2 reserved mul, 3 MUL Rd==Rm
// BEHAVIOUR
// - Reset: FIFO empty, out_valid=0, out_instr=0, out_addr=0, err_valid=0, err_code=0; in_ready=1 once rst_n is released.
// - Accept on in_valid&&in_ready; encode combinationally; push at that edge. out_valid rises the next cycle (latency 1).
// - in_ready depends only on full: no pass-through when full, even with a simultaneous pop.
// - Pop on out_valid&&out_ready; out_addr increments by 1 per pop, wraps 2**ADDR_W-1 -> 0.
// - Push and pop in the same cycle: occupancy unchanged, both pointers advance.
// - DP word: {COND,2'b00,I,opcode,S,Rn,Rd,op2}.
//   - op2 imm: {rot,imm8}
//   - op2 reg imm-shift: {amt,type,1'b0,Rm}
//   - op2 reg-shift: {Rs,1'b0,type,1'b1,Rm}
// - DP forcing: opcodes 1000-1011 (TST/TEQ/CMP/CMN) force S=1 and Rd=0; 1101/1111 (MOV/MVN) force Rn=0.
// - MUL word: {COND,4'b0000,mul,S,Rd,Rn,Rs,4'b1001,Rm}; MUL (000) forces bits[15:12]=0.
// - Illegal bundle is accepted (consumes the handshake) but not pushed. err_valid pulses the next cycle with err_code.
//   - Error priority: kind > mul > Rd==Rm.
//   - Rd==Rm applies to MUL/MLA only.
//   - err_code holds until the next error.
// - Async reset mid-operation: FIFO flushed, address and error cleared immediately; pending words are lost.
// STRUCTURE
// - Package arm_enc_pkg:
//   - KIND_DP/KIND_MUL
//   - OP_AND..OP_MVN, MUL_* codes, ERR_* codes
//   - COND_AL, MUL_SIG=4'b1001
//   - encode function for the DP/MUL word
// - Sub-module enc_fifo (DEPTH x 32, registered head, full/empty, async active-low reset).
// - Top holds: encode logic, legality check, address counter, error register.
// TESTING
// - ADD r1,r2,#5 (kind0,op0100,I=1,imm8=5,rot=0) -> out_instr=E2821005, out_addr=0, one cycle after accept.
// - MOV r0,r1,LSL#2 (op1101,I=0,amt=2,Rn=7 supplied) -> E1A00101 (Rn forced 0), out_addr=1.
// - CMP r3,#0 with in_s=0, in_rd=9 -> E3530000 (S forced 1, Rd forced 0).
// - MUL r4,r5,r6 (Rd=4,Rm=5,Rs=6,Rn=3 supplied) -> E0040695. MUL Rd=5,Rm=5 -> no push, err_valid pulse, err_code=3.
// - in_kind=2 -> no out_valid, err_code=1. in_mul=010 -> err_code=2.
// - DEPTH=4, ADDR_W=2, out_ready=0, 5 pushes -> in_ready low after the 4th. Then drain -> addrs 0,1,2,3. Next word wraps to addr 0.
// - Assert rst_n=0 with 3 words queued -> out_valid=0 immediately; after release, the first word emitted gets out_addr=0.

Source files
------------

// File: rtl/arm_enc_pkg.sv
// arm_enc_pkg: field codes, bundle type and word packer for the ARM instruction encoder
package arm_enc_pkg;

    localparam logic [1:0] KIND_DP  = 2'd0;
    localparam logic [1:0] KIND_MUL = 2'd1;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [2:0] MUL_MUL   = 3'b000;
    localparam logic [2:0] MUL_MLA   = 3'b001;
    localparam logic [2:0] MUL_UMULL = 3'b100;
    localparam logic [2:0] MUL_UMLAL = 3'b101;
    localparam logic [2:0] MUL_SMULL = 3'b110;
    localparam logic [2:0] MUL_SMLAL = 3'b111;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_KIND = 2'd1;
    localparam logic [1:0] ERR_MUL  = 2'd2;
    localparam logic [1:0] ERR_RDRM = 2'd3;

    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] MUL_SIG = 4'b1001;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] opcode;
        logic [2:0] mul;
        logic       s;
        logic       imm_mode;
        logic [3:0] rn;
        logic [3:0] rd;
        logic [3:0] rm;
        logic [3:0] rs;
        logic [7:0] imm8;
        logic [3:0] rot;
        logic [1:0] shift_type;
        logic [4:0] shift_amt;
        logic       reg_shift;
    } fields_t;

    // Compare ops always set flags and have no destination; MOV/MVN have no first operand.
    function automatic logic [31:0] encode(input fields_t f, input logic [3:0] cond);
        logic        cmp_op;
        logic        mov_op;
        logic [11:0] op2;
        cmp_op = f.opcode[3:2] == 2'b10;
        mov_op = f.opcode == OP_MOV || f.opcode == OP_MVN;
        op2 = f.imm_mode  ? {f.rot, f.imm8} :
              f.reg_shift ? {f.rs, 1'b0, f.shift_type, 1'b1, f.rm} :
                            {f.shift_amt, f.shift_type, 1'b0, f.rm};
        if (f.kind == KIND_MUL)
            return {cond, 4'b0000, f.mul, f.s, f.rd, (f.mul == MUL_MUL) ? 4'h0 : f.rn, f.rs, MUL_SIG, f.rm};
        return {cond, 2'b00, f.imm_mode, f.opcode, f.s | cmp_op, mov_op ? 4'h0 : f.rn, cmp_op ? 4'h0 : f.rd, op2};
    endfunction

endpackage

// File: rtl/arm_instr_encoder_fifo.sv
// enc_fifo: DEPTH x W word FIFO with count-based full/empty and a zeroed head when empty
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // Pointer and occupancy state, flushed by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arm_instr_encoder.sv
// arm_instr_encoder: packs DP/MUL field bundles into ARM words, queues them and emits them with an address
module arm_instr_encoder
    import arm_enc_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter int         DEPTH  = 4,
    parameter logic [3:0] COND   = COND_AL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_mul,
    input  logic              in_s,
    input  logic              in_imm_mode,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rm,
    input  logic [3:0]        in_rs,
    input  logic [7:0]        in_imm8,
    input  logic [3:0]        in_rot,
    input  logic [1:0]        in_shift_type,
    input  logic [4:0]        in_shift_amt,
    input  logic              in_reg_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code
);
    fields_t           f;
    logic [31:0]       word;
    logic [1:0]        err;
    logic              accept, push, pop, full, empty;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;

    assign f = '{kind: in_kind, opcode: in_opcode, mul: in_mul, s: in_s, imm_mode: in_imm_mode,
                 rn: in_rn, rd: in_rd, rm: in_rm, rs: in_rs, imm8: in_imm8, rot: in_rot,
                 shift_type: in_shift_type, shift_amt: in_shift_amt, reg_shift: in_reg_shift};
    assign word      = encode(f, COND);
    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && err == ERR_NONE;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_addr  = addr_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

    // Legality, highest priority first: reserved kind, reserved MUL sub-op, short MUL with Rd==Rm.
    always_comb begin
        err = in_kind[1]                                             ? ERR_KIND :
              in_kind == KIND_MUL && in_mul[2:1] == 2'b01            ? ERR_MUL  :
              in_kind == KIND_MUL && !in_mul[2] && in_rd == in_rm    ? ERR_RDRM :
                                                                       ERR_NONE;
    end

    // Address follows consumed words; the error code is sticky until the next illegal bundle.
    always_comb begin
        addr_d      = addr_q + ADDR_W'(pop);
        err_valid_d = accept && err != ERR_NONE;
        err_code_d  = err_valid_d ? err : err_code_q;
    end

    // Address counter and error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            addr_q      <= addr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (word),
        .pop_i   (pop),
        .data_o  (out_instr),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_arm_instr_encoder.sv
// tb_arm_instr_encoder: directed vector table, FIFO/reset sequences and random traffic against a reference model
module tb_arm_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] opcode;
        logic [2:0] mul;
        logic       s;
        logic       imm;
        logic [3:0] rn, rd, rm, rs;
        logic [7:0] imm8;
        logic [3:0] rot;
        logic [1:0] st;
        logic [4:0] amt;
        logic       rsh;
    } bundle_t;

    typedef struct {
        bundle_t     b;
        logic [31:0] exp;
        logic [1:0]  err;
    } vec_t;

    logic              clk, rst_n;
    logic              in_valid, in_ready;
    logic [1:0]        in_kind;
    logic [3:0]        in_opcode;
    logic [2:0]        in_mul;
    logic              in_s, in_imm_mode;
    logic [3:0]        in_rn, in_rd, in_rm, in_rs;
    logic [7:0]        in_imm8;
    logic [3:0]        in_rot;
    logic [1:0]        in_shift_type;
    logic [4:0]        in_shift_amt;
    logic              in_reg_shift;
    logic              out_valid, out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_valid;
    logic [1:0]        err_code;

    int errors = 0;
    int checks = 0;

    arm_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .COND(4'hE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_opcode(in_opcode), .in_mul(in_mul), .in_s(in_s),
        .in_imm_mode(in_imm_mode), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm), .in_rs(in_rs),
        .in_imm8(in_imm8), .in_rot(in_rot), .in_shift_type(in_shift_type),
        .in_shift_amt(in_shift_amt), .in_reg_shift(in_reg_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_valid(err_valid), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input int kind, input int op, input int mul, input int s, input int imm,
                                   input int rn, input int rd, input int rm, input int rs, input int imm8,
                                   input int rot, input int st, input int amt, input int rsh);
        bundle_t b;
        b.kind = 2'(kind); b.opcode = 4'(op); b.mul = 3'(mul); b.s = 1'(s); b.imm = 1'(imm);
        b.rn = 4'(rn); b.rd = 4'(rd); b.rm = 4'(rm); b.rs = 4'(rs); b.imm8 = 8'(imm8);
        b.rot = 4'(rot); b.st = 2'(st); b.amt = 5'(amt); b.rsh = 1'(rsh);
        return b;
    endfunction

    function automatic bundle_t rnd_bundle();
        bundle_t b;
        b = mk(0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom);
        b.kind = ($urandom % 8 == 0) ? 2'(2 + $urandom % 2) : 2'($urandom % 2);
        return b;
    endfunction

    // Error classification straight from the instruction-set rules.
    function automatic logic [1:0] ref_err(input bundle_t b);
        if (b.kind > 1) return 2'd1;
        if (b.kind == 1 && !(b.mul inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7})) return 2'd2;
        if (b.kind == 1 && b.mul inside {3'd0, 3'd1} && b.rd == b.rm) return 2'd3;
        return 2'd0;
    endfunction

    // Expected ARM word assembled field by field with integer arithmetic.
    function automatic logic [31:0] ref_word(input bundle_t b);
        int unsigned w, op2, rn_f, rd_f, s_f;
        bit compare_op, move_op;
        w = 32'hE000_0000;
        if (b.kind == 1) begin
            rn_f = (b.mul == 0) ? 0 : int'(b.rn);
            w += int'(b.mul) * (1 << 21) + int'(b.s) * (1 << 20) + int'(b.rd) * (1 << 16)
               + rn_f * (1 << 12) + int'(b.rs) * (1 << 8) + 9 * 16 + int'(b.rm);
            return w;
        end
        compare_op = b.opcode inside {4'd8, 4'd9, 4'd10, 4'd11};
        move_op    = b.opcode inside {4'd13, 4'd15};
        s_f  = compare_op ? 1 : int'(b.s);
        rd_f = compare_op ? 0 : int'(b.rd);
        rn_f = move_op ? 0 : int'(b.rn);
        if (b.imm)      op2 = int'(b.rot) * 256 + int'(b.imm8);
        else if (b.rsh) op2 = int'(b.rs) * 256 + int'(b.st) * 32 + 16 + int'(b.rm);
        else            op2 = int'(b.amt) * 128 + int'(b.st) * 32 + int'(b.rm);
        w += int'(b.imm) * (1 << 25) + int'(b.opcode) * (1 << 21) + s_f * (1 << 20)
           + rn_f * (1 << 16) + rd_f * (1 << 12) + op2;
        return w;
    endfunction

    task automatic drive(input bundle_t b);
        in_kind = b.kind; in_opcode = b.opcode; in_mul = b.mul; in_s = b.s; in_imm_mode = b.imm;
        in_rn = b.rn; in_rd = b.rd; in_rm = b.rm; in_rs = b.rs; in_imm8 = b.imm8; in_rot = b.rot;
        in_shift_type = b.st; in_shift_amt = b.amt; in_reg_shift = b.rsh;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #3;
        rst_n     = 1'b1;
        step();
    endtask

    vec_t        tbl [14];
    bundle_t     b;
    logic [31:0] q [$];
    int          addr_m;
    logic [1:0]  ec_m, e;
    logic        ev_m, acc, pop;

    initial begin
        tbl[0]  = '{mk(0, 4, 0, 0, 1, 2, 1, 0, 0, 5, 0, 0, 0, 0),     32'hE2821005, 2'd0};
        tbl[1]  = '{mk(0, 13, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0, 2, 0),    32'hE1A00101, 2'd0};
        tbl[2]  = '{mk(0, 10, 0, 0, 1, 3, 9, 0, 0, 0, 0, 0, 0, 0),    32'hE3530000, 2'd0};
        tbl[3]  = '{mk(1, 0, 0, 0, 0, 3, 4, 5, 6, 0, 0, 0, 0, 0),     32'hE0040695, 2'd0};
        tbl[4]  = '{mk(1, 0, 0, 0, 0, 0, 5, 5, 6, 0, 0, 0, 0, 0),     32'h0,        2'd3};
        tbl[5]  = '{mk(2, 4, 0, 0, 1, 2, 1, 0, 0, 5, 0, 0, 0, 0),     32'h0,        2'd1};
        tbl[6]  = '{mk(1, 0, 2, 0, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0),     32'h0,        2'd2};
        tbl[7]  = '{mk(0, 12, 0, 1, 0, 2, 1, 3, 4, 0, 0, 2, 0, 1),    32'hE1921453, 2'd0};
        tbl[8]  = '{mk(1, 0, 5, 1, 0, 2, 1, 3, 4, 0, 0, 0, 0, 0),     32'hE0B12493, 2'd0};
        tbl[9]  = '{mk(0, 15, 0, 0, 1, 5, 6, 0, 0, 255, 4, 0, 0, 0),  32'hE3E064FF, 2'd0};
        tbl[10] = '{mk(1, 0, 1, 0, 0, 0, 2, 2, 3, 0, 0, 0, 0, 0),     32'h0,        2'd3};
        tbl[11] = '{mk(1, 0, 4, 0, 0, 1, 3, 3, 2, 0, 0, 0, 0, 0),     32'hE0831293, 2'd0};
        tbl[12] = '{mk(3, 0, 2, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0),     32'h0,        2'd1};
        tbl[13] = '{mk(0, 8, 0, 0, 0, 1, 7, 2, 0, 0, 0, 0, 0, 0),     32'hE1110002, 2'd0};

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        #22;
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);

        // Directed vectors: one bundle at a time, consumer always ready.
        addr_m = 0; ec_m = 0; out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].b);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (tbl[i].err != 0) ec_m = tbl[i].err;
            chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].err == 0);
            chk($sformatf("vec%0d_err_valid", i), err_valid, tbl[i].err != 0);
            chk($sformatf("vec%0d_err_code", i), err_code, ec_m);
            if (tbl[i].err == 0) begin
                chk($sformatf("vec%0d_instr", i), out_instr, tbl[i].exp);
                chk($sformatf("vec%0d_model", i), out_instr, ref_word(tbl[i].b));
                chk($sformatf("vec%0d_addr", i), out_addr, addr_m);
                addr_m = (addr_m + 1) % 4;
            end
            step();
            chk($sformatf("vec%0d_drained", i), out_valid, 0);
            chk($sformatf("vec%0d_err_pulse", i), err_valid, 0);
        end

        // Fill to full with the consumer stalled, then drain and wrap the address.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_ready%0d", i), in_ready, i < 4);
            drive(mk(0, 4, 0, 0, 1, 2, 1, 0, 0, i, 0, 0, 0, 0));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("full_ready_after", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), out_valid, 1);
            chk($sformatf("drain%0d_instr", k), out_instr, ref_word(mk(0, 4, 0, 0, 1, 2, 1, 0, 0, k, 0, 0, 0, 0)));
            chk($sformatf("drain%0d_addr", k), out_addr, k);
            step();
        end
        chk("drain_empty", out_valid, 0);
        drive(mk(0, 4, 0, 0, 1, 2, 1, 0, 0, 9, 0, 0, 0, 0));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("wrap_valid", out_valid, 1);
        chk("wrap_addr", out_addr, 0);
        chk("wrap_instr", out_instr, 32'hE2821009);
        step();

        // Asynchronous reset with words queued and a latched error code.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 4, 0, 0, 1, 2, 1, 0, 0, 16 + i, 0, 0, 0, 0));
            in_valid = 1'b1;
            step();
        end
        drive(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_addr", out_addr, 1);
        chk("pre_rst_err_code", err_code, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_addr", out_addr, 0);
        chk("arst_err_code", err_code, 0);
        chk("arst_err_valid", err_valid, 0);
        #2;
        rst_n = 1'b1;
        step();
        drive(mk(0, 4, 0, 0, 1, 2, 1, 0, 0, 7, 0, 0, 0, 0));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_addr", out_addr, 0);
        chk("post_rst_instr", out_instr, 32'hE2821007);

        // Random traffic with random back-pressure against the queue model.
        do_reset();
        q.delete(); addr_m = 0; ec_m = 0; ev_m = 0;
        for (int i = 0; i < 400; i++) begin
            chk("rnd_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("rnd_instr", out_instr, q[0]);
                chk("rnd_addr", out_addr, addr_m);
            end
            chk("rnd_ready", in_ready, q.size() < DEPTH);
            chk("rnd_err_valid", err_valid, ev_m);
            chk("rnd_err_code", err_code, ec_m);
            b = rnd_bundle();
            drive(b);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            acc = in_valid && q.size() < DEPTH;
            pop = q.size() != 0 && out_ready;
            e   = ref_err(b);
            step();
            if (pop) begin
                void'(q.pop_front());
                addr_m = (addr_m + 1) % 4;
            end
            if (acc && e == 0) q.push_back(ref_word(b));
            ev_m = acc && e != 0;
            if (ev_m) ec_m = e;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
